// File: rtl/inv_sub_bytes_seq.sv
// rtl/inv_sub_bytes_seq.sv - AES InvSubBytes engine, BPC inverse S-box lookups per cycle
// Accepts a 128-bit state, substitutes it in 16/BPC cycles and holds it until taken.
module inv_sub_bytes_seq #(
  parameter int BPC = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  generate
    if (BPC != 1 && BPC != 2 && BPC != 4 && BPC != 8 && BPC != 16) begin : g_bad_bpc
      $error("inv_sub_bytes_seq: BPC must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  localparam logic [3:0] LAST = 4'(16 / BPC - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_n;
  logic [3:0]       cnt, cnt_n;
  logic [15:0][7:0] st, st_n;
  logic [3:0]       pos;

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [7:0] r;
    r = 8'h00;
    case (b)
      8'h00: r = 8'h52; 8'h01: r = 8'h09; 8'h02: r = 8'h6a; 8'h03: r = 8'hd5; 8'h04: r = 8'h30; 8'h05: r = 8'h36; 8'h06: r = 8'ha5; 8'h07: r = 8'h38;
      8'h08: r = 8'hbf; 8'h09: r = 8'h40; 8'h0a: r = 8'ha3; 8'h0b: r = 8'h9e; 8'h0c: r = 8'h81; 8'h0d: r = 8'hf3; 8'h0e: r = 8'hd7; 8'h0f: r = 8'hfb;
      8'h10: r = 8'h7c; 8'h11: r = 8'he3; 8'h12: r = 8'h39; 8'h13: r = 8'h82; 8'h14: r = 8'h9b; 8'h15: r = 8'h2f; 8'h16: r = 8'hff; 8'h17: r = 8'h87;
      8'h18: r = 8'h34; 8'h19: r = 8'h8e; 8'h1a: r = 8'h43; 8'h1b: r = 8'h44; 8'h1c: r = 8'hc4; 8'h1d: r = 8'hde; 8'h1e: r = 8'he9; 8'h1f: r = 8'hcb;
      8'h20: r = 8'h54; 8'h21: r = 8'h7b; 8'h22: r = 8'h94; 8'h23: r = 8'h32; 8'h24: r = 8'ha6; 8'h25: r = 8'hc2; 8'h26: r = 8'h23; 8'h27: r = 8'h3d;
      8'h28: r = 8'hee; 8'h29: r = 8'h4c; 8'h2a: r = 8'h95; 8'h2b: r = 8'h0b; 8'h2c: r = 8'h42; 8'h2d: r = 8'hfa; 8'h2e: r = 8'hc3; 8'h2f: r = 8'h4e;
      8'h30: r = 8'h08; 8'h31: r = 8'h2e; 8'h32: r = 8'ha1; 8'h33: r = 8'h66; 8'h34: r = 8'h28; 8'h35: r = 8'hd9; 8'h36: r = 8'h24; 8'h37: r = 8'hb2;
      8'h38: r = 8'h76; 8'h39: r = 8'h5b; 8'h3a: r = 8'ha2; 8'h3b: r = 8'h49; 8'h3c: r = 8'h6d; 8'h3d: r = 8'h8b; 8'h3e: r = 8'hd1; 8'h3f: r = 8'h25;
      8'h40: r = 8'h72; 8'h41: r = 8'hf8; 8'h42: r = 8'hf6; 8'h43: r = 8'h64; 8'h44: r = 8'h86; 8'h45: r = 8'h68; 8'h46: r = 8'h98; 8'h47: r = 8'h16;
      8'h48: r = 8'hd4; 8'h49: r = 8'ha4; 8'h4a: r = 8'h5c; 8'h4b: r = 8'hcc; 8'h4c: r = 8'h5d; 8'h4d: r = 8'h65; 8'h4e: r = 8'hb6; 8'h4f: r = 8'h92;
      8'h50: r = 8'h6c; 8'h51: r = 8'h70; 8'h52: r = 8'h48; 8'h53: r = 8'h50; 8'h54: r = 8'hfd; 8'h55: r = 8'hed; 8'h56: r = 8'hb9; 8'h57: r = 8'hda;
      8'h58: r = 8'h5e; 8'h59: r = 8'h15; 8'h5a: r = 8'h46; 8'h5b: r = 8'h57; 8'h5c: r = 8'ha7; 8'h5d: r = 8'h8d; 8'h5e: r = 8'h9d; 8'h5f: r = 8'h84;
      8'h60: r = 8'h90; 8'h61: r = 8'hd8; 8'h62: r = 8'hab; 8'h63: r = 8'h00; 8'h64: r = 8'h8c; 8'h65: r = 8'hbc; 8'h66: r = 8'hd3; 8'h67: r = 8'h0a;
      8'h68: r = 8'hf7; 8'h69: r = 8'he4; 8'h6a: r = 8'h58; 8'h6b: r = 8'h05; 8'h6c: r = 8'hb8; 8'h6d: r = 8'hb3; 8'h6e: r = 8'h45; 8'h6f: r = 8'h06;
      8'h70: r = 8'hd0; 8'h71: r = 8'h2c; 8'h72: r = 8'h1e; 8'h73: r = 8'h8f; 8'h74: r = 8'hca; 8'h75: r = 8'h3f; 8'h76: r = 8'h0f; 8'h77: r = 8'h02;
      8'h78: r = 8'hc1; 8'h79: r = 8'haf; 8'h7a: r = 8'hbd; 8'h7b: r = 8'h03; 8'h7c: r = 8'h01; 8'h7d: r = 8'h13; 8'h7e: r = 8'h8a; 8'h7f: r = 8'h6b;
      8'h80: r = 8'h3a; 8'h81: r = 8'h91; 8'h82: r = 8'h11; 8'h83: r = 8'h41; 8'h84: r = 8'h4f; 8'h85: r = 8'h67; 8'h86: r = 8'hdc; 8'h87: r = 8'hea;
      8'h88: r = 8'h97; 8'h89: r = 8'hf2; 8'h8a: r = 8'hcf; 8'h8b: r = 8'hce; 8'h8c: r = 8'hf0; 8'h8d: r = 8'hb4; 8'h8e: r = 8'he6; 8'h8f: r = 8'h73;
      8'h90: r = 8'h96; 8'h91: r = 8'hac; 8'h92: r = 8'h74; 8'h93: r = 8'h22; 8'h94: r = 8'he7; 8'h95: r = 8'had; 8'h96: r = 8'h35; 8'h97: r = 8'h85;
      8'h98: r = 8'he2; 8'h99: r = 8'hf9; 8'h9a: r = 8'h37; 8'h9b: r = 8'he8; 8'h9c: r = 8'h1c; 8'h9d: r = 8'h75; 8'h9e: r = 8'hdf; 8'h9f: r = 8'h6e;
      8'ha0: r = 8'h47; 8'ha1: r = 8'hf1; 8'ha2: r = 8'h1a; 8'ha3: r = 8'h71; 8'ha4: r = 8'h1d; 8'ha5: r = 8'h29; 8'ha6: r = 8'hc5; 8'ha7: r = 8'h89;
      8'ha8: r = 8'h6f; 8'ha9: r = 8'hb7; 8'haa: r = 8'h62; 8'hab: r = 8'h0e; 8'hac: r = 8'haa; 8'had: r = 8'h18; 8'hae: r = 8'hbe; 8'haf: r = 8'h1b;
      8'hb0: r = 8'hfc; 8'hb1: r = 8'h56; 8'hb2: r = 8'h3e; 8'hb3: r = 8'h4b; 8'hb4: r = 8'hc6; 8'hb5: r = 8'hd2; 8'hb6: r = 8'h79; 8'hb7: r = 8'h20;
      8'hb8: r = 8'h9a; 8'hb9: r = 8'hdb; 8'hba: r = 8'hc0; 8'hbb: r = 8'hfe; 8'hbc: r = 8'h78; 8'hbd: r = 8'hcd; 8'hbe: r = 8'h5a; 8'hbf: r = 8'hf4;
      8'hc0: r = 8'h1f; 8'hc1: r = 8'hdd; 8'hc2: r = 8'ha8; 8'hc3: r = 8'h33; 8'hc4: r = 8'h88; 8'hc5: r = 8'h07; 8'hc6: r = 8'hc7; 8'hc7: r = 8'h31;
      8'hc8: r = 8'hb1; 8'hc9: r = 8'h12; 8'hca: r = 8'h10; 8'hcb: r = 8'h59; 8'hcc: r = 8'h27; 8'hcd: r = 8'h80; 8'hce: r = 8'hec; 8'hcf: r = 8'h5f;
      8'hd0: r = 8'h60; 8'hd1: r = 8'h51; 8'hd2: r = 8'h7f; 8'hd3: r = 8'ha9; 8'hd4: r = 8'h19; 8'hd5: r = 8'hb5; 8'hd6: r = 8'h4a; 8'hd7: r = 8'h0d;
      8'hd8: r = 8'h2d; 8'hd9: r = 8'he5; 8'hda: r = 8'h7a; 8'hdb: r = 8'h9f; 8'hdc: r = 8'h93; 8'hdd: r = 8'hc9; 8'hde: r = 8'h9c; 8'hdf: r = 8'hef;
      8'he0: r = 8'ha0; 8'he1: r = 8'he0; 8'he2: r = 8'h3b; 8'he3: r = 8'h4d; 8'he4: r = 8'hae; 8'he5: r = 8'h2a; 8'he6: r = 8'hf5; 8'he7: r = 8'hb0;
      8'he8: r = 8'hc8; 8'he9: r = 8'heb; 8'hea: r = 8'hbb; 8'heb: r = 8'h3c; 8'hec: r = 8'h83; 8'hed: r = 8'h53; 8'hee: r = 8'h99; 8'hef: r = 8'h61;
      8'hf0: r = 8'h17; 8'hf1: r = 8'h2b; 8'hf2: r = 8'h04; 8'hf3: r = 8'h7e; 8'hf4: r = 8'hba; 8'hf5: r = 8'h77; 8'hf6: r = 8'hd6; 8'hf7: r = 8'h26;
      8'hf8: r = 8'he1; 8'hf9: r = 8'h69; 8'hfa: r = 8'h14; 8'hfb: r = 8'h63; 8'hfc: r = 8'h55; 8'hfd: r = 8'h21; 8'hfe: r = 8'h0c; 8'hff: r = 8'h7d;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      st    <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      st    <= st_n;
    end
  end

  // Byte 0 lives in st[15] ([127:120]), so byte k of the state is st[15-k].
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    st_n    = st;
    pos     = '0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          st_n    = in_data;
          cnt_n   = '0;
          state_n = BUSY;
        end
      end
      BUSY: begin
        for (int j = 0; j < BPC; j++) begin
          pos = cnt * 4'(BPC) + 4'(j);
          st_n[4'd15 - pos] = inv_sbox(st[4'd15 - pos]);
        end
        if (cnt == LAST) state_n = DONE;
        else             cnt_n   = cnt + 4'd1;
      end
      DONE: begin
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == BUSY);
  assign out_data  = st;

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// tb/tb_inv_sub_bytes_seq.sv - scoreboard bench for inv_sub_bytes_seq at BPC 1, 2, 4 and 16
// DUT index d: 0 -> BPC=1, 1 -> BPC=2, 2 -> BPC=4, 3 -> BPC=16.
module tb_inv_sub_bytes_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   in_valid;
  logic [3:0]   out_ready;
  logic [127:0] in_data [4];
  wire  [3:0]   in_ready;
  wire  [3:0]   out_valid;
  wire  [3:0]   busy;
  wire  [127:0] out_data [4];

  int tests = 0;
  int fails = 0;
  int rx [4];

  logic [7:0]   fwd [256];
  logic [7:0]   inv [256];
  logic [127:0] q0[$], q1[$], q2[$], q3[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int B = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : 16;
    inv_sub_bytes_seq #(.BPC(B)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid[g]),
      .in_ready (in_ready[g]),
      .in_data  (in_data[g]),
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g]),
      .out_data (out_data[g]),
      .busy     (busy[g])
    );
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic void push(input int d, input logic [127:0] v);
    case (d)
      0: q0.push_back(v);
      1: q1.push_back(v);
      2: q2.push_back(v);
      default: q3.push_back(v);
    endcase
  endfunction

  function automatic int qsize(input int d);
    case (d)
      0: return q0.size();
      1: return q1.size();
      2: return q2.size();
      default: return q3.size();
    endcase
  endfunction

  function automatic logic [127:0] pop(input int d);
    case (d)
      0: return q0.pop_front();
      1: return q1.pop_front();
      2: return q2.pop_front();
      default: return q3.pop_front();
    endcase
  endfunction

  function automatic logic [127:0] model(input logic [127:0] x);
    logic [127:0] y;
    for (int i = 0; i < 16; i++) y[8*(15-i) +: 8] = inv[x[8*(15-i) +: 8]];
    return y;
  endfunction

  // Monitor: pops the scoreboard on every output handshake and checks hold-under-stall.
  logic [127:0] pd [4];
  bit           pv [4];
  bit           pr [4];
  always @(negedge clk) begin
    for (int d = 0; d < 4; d++) begin
      if (rst) begin
        pv[d] = 1'b0;
      end else begin
        if (pv[d] && !pr[d]) begin
          chk($sformatf("hold_valid%0d", d), out_valid[d], 1'b1);
          chk($sformatf("hold_data%0d", d), out_data[d], pd[d]);
        end
        if (out_valid[d] && out_ready[d]) begin
          if (qsize(d) == 0) chk($sformatf("unexpected_output%0d", d), 1'b1, 1'b0);
          else               chk($sformatf("out_data%0d", d), out_data[d], pop(d));
          rx[d]++;
        end
        pv[d] = out_valid[d];
        pr[d] = out_ready[d];
        pd[d] = out_data[d];
      end
    end
  end

  task automatic send(input int d, input logic [127:0] data, input logic [127:0] exp);
    bit ok;
    ok = 1'b0;
    push(d, exp);
    @(posedge clk); #1;
    in_valid[d] = 1'b1;
    in_data[d]  = data;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (in_ready[d]) begin ok = 1'b1; break; end
    end
    if (!ok) chk($sformatf("accept_timeout%0d", d), 1'b0, 1'b1);
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
    in_data[d]  = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Called just after the accept edge; counts edges until out_valid and busy-high samples.
  task automatic wait_out(input int d, input int lat_exp, input int busy_exp, input string name);
    int lat, nb;
    lat = 0;
    nb  = busy[d] ? 1 : 0;
    while (!out_valid[d] && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (busy[d]) nb++;
    end
    chk({name, "_latency"}, 128'(lat), 128'(lat_exp));
    chk({name, "_busy_cycles"}, 128'(nb), 128'(busy_exp));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [127:0] din, dexp;
    bit stress_done;
    fwd = '{
      8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
      8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
      8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
      8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
      8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
      8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
      8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
      8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
      8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
      8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
      8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
      8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
      8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
      8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
      8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
      8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16};
    for (int i = 0; i < 256; i++) inv[fwd[i]] = 8'(i);
    for (int d = 0; d < 4; d++) begin
      in_data[d] = '0;
      rx[d] = 0;
    end
    rst = 1'b1;
    in_valid = '0;
    out_ready = 4'hf;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("reset_in_ready%0d", d), in_ready[d], 1'b1);
      chk($sformatf("reset_out_valid%0d", d), out_valid[d], 1'b0);
      chk($sformatf("reset_busy%0d", d), busy[d], 1'b0);
      chk($sformatf("reset_out_data%0d", d), out_data[d], 128'h0);
    end

    // Full known vector at BPC=1.
    send(0, 128'h637c777bf26b6fc53001672bfed7ab76, 128'h000102030405060708090a0b0c0d0e0f);
    wait_out(0, 16, 16, "bpc1_vec");

    // Boundary bytes at BPC=4.
    send(2, 128'h00ff5263_00ff5263_00ff5263_00ff5263, 128'h527d4800_527d4800_527d4800_527d4800);
    wait_out(2, 4, 4, "bpc4_boundary");

    // Round trip of all 256 S-box outputs at BPC=16.
    for (int t = 0; t < 16; t++) begin
      for (int i = 0; i < 16; i++) begin
        din[8*(15-i) +: 8]  = fwd[16*t + i];
        dexp[8*(15-i) +: 8] = 8'(16*t + i);
      end
      send(3, din, dexp);
      wait_out(3, 1, 1, $sformatf("bpc16_rt%0d", t));
    end

    // Output backpressure with a second state pending at BPC=1.
    out_ready[0] = 1'b0;
    send(0, 128'h00ff5263_00ff5263_00ff5263_00ff5263, 128'h527d4800_527d4800_527d4800_527d4800);
    wait_out(0, 16, 16, "bp_first");
    push(0, 128'h000102030405060708090a0b0c0d0e0f);
    in_valid[0] = 1'b1;
    in_data[0]  = 128'h637c777bf26b6fc53001672bfed7ab76;
    for (int c = 0; c < 20; c++) begin
      chk("bp_out_valid", out_valid[0], 1'b1);
      chk("bp_out_data", out_data[0], 128'h527d4800_527d4800_527d4800_527d4800);
      chk("bp_in_ready", in_ready[0], 1'b0);
      @(posedge clk); #1;
    end
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    chk("bp_ready_after_consume", in_ready[0], 1'b1);
    chk("bp_not_accepted_early", busy[0], 1'b0);
    @(posedge clk); #1;
    chk("bp_accept_next_edge", busy[0], 1'b1);
    in_valid[0] = 1'b0;
    in_data[0]  = {$urandom, $urandom, $urandom, $urandom};
    wait_out(0, 16, 16, "bp_second");

    // Asynchronous reset seven edges into a BPC=1 substitution.
    @(posedge clk); @(posedge clk);
    send(0, 128'h637c777bf26b6fc53001672bfed7ab76, 128'h000102030405060708090a0b0c0d0e0f);
    repeat (6) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("rst_busy", busy[0], 1'b0);
    chk("rst_out_valid", out_valid[0], 1'b0);
    chk("rst_out_data", out_data[0], 128'h0);
    q0.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_in_ready", in_ready[0], 1'b1);
    send(0, 128'h8ca1890dbfe6426841992d0fb054bb16, 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff);
    wait_out(0, 16, 16, "after_rst");

    // Random handshake stress at BPC=2 against the table model.
    stress_done = 1'b0;
    fork
      begin
        logic [127:0] r;
        for (int t = 0; t < 1000; t++) begin
          repeat ($urandom_range(0, 2)) @(posedge clk);
          r = {$urandom, $urandom, $urandom, $urandom};
          send(1, r, model(r));
        end
        stress_done = 1'b1;
      end
      begin
        while (!stress_done) begin
          @(posedge clk); #1;
          out_ready[1] = 1'($urandom_range(0, 1));
        end
        out_ready[1] = 1'b1;
      end
    join

    for (int n = 0; n < 200; n++) begin
      if (qsize(0) + qsize(1) + qsize(2) + qsize(3) == 0) break;
      @(posedge clk);
    end
    @(posedge clk); #1;
    for (int d = 0; d < 4; d++) chk($sformatf("drain_queue%0d", d), 128'(qsize(d)), 128'h0);
    chk("stress_count", 128'(rx[1]), 128'd1000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
